// File: rtl/spi_read_sequencer.sv
// SPI flash read sequencer: emits command/address/dummy/data bytes to the SPI
// transmit FIFO, tracks in-flight bytes, and passes data bytes straight back.
// Build option: define SPI_FAST_READ_EN for FAST READ (0x0B + one dummy byte);
// otherwise plain READ (0x03, no dummy byte).
module spi_read_sequencer (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [23:0] ReqAddr,
  input  logic [7:0]  ReqLen,
  input  logic        Abort,
  output logic        TxValid,
  input  logic        TxReady,
  output logic [7:0]  TxData,
  input  logic        RxValid,
  input  logic [7:0]  RxData,
  output logic        RspValid,
  output logic [7:0]  RspData,
  output logic        RspLast,
  output logic        CSHold,
  output logic        Busy
);

  localparam int unsigned AddrW = 24;
  localparam int unsigned LenW  = 8;
  localparam int unsigned ByteW = 8;
  localparam int unsigned CntW  = 9;
  localparam int unsigned OutW  = 3;

  localparam logic [OutW-1:0] MaxOutstanding = OutW'(4);

`ifdef SPI_FAST_READ_EN
  localparam logic [ByteW-1:0] CmdByte   = 8'h0B;
  localparam logic [CntW-1:0]  HeaderLen = CntW'(5);
`else
  localparam logic [ByteW-1:0] CmdByte   = 8'h03;
  localparam logic [CntW-1:0]  HeaderLen = CntW'(4);
`endif

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, WAITRX, DONE, FLUSH
  } state_t;

  state_t            state, stateNext;
  logic [AddrW-1:0]  addrQ;
  logic [LenW-1:0]   lenQ;
  logic [CntW-1:0]   txCount, rxCount, lastIdx;
  logic [OutW-1:0]   outCount;
  logic              inTxn, txCan, txFire, rxTake, reqTake;

  // Index of the final byte, shared by the tx and rx streams
  assign lastIdx = HeaderLen + CntW'(lenQ);

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state and outputs; Abort has the final say over the next state
  always_comb begin
    stateNext = state;
    ReqReady  = 1'b0;
    TxValid   = 1'b0;
    TxData    = '0;
    RspValid  = 1'b0;
    RspData   = '0;
    RspLast   = 1'b0;
    inTxn     = (state == CMD) || (state == ADDR) || (state == DUMMY) ||
                (state == DATA) || (state == WAITRX);
    CSHold    = inTxn;
    Busy      = (state != IDLE);
    txCan     = (outCount != MaxOutstanding);
    reqTake   = 1'b0;

    case (state)
      IDLE: begin
        ReqReady = !PRESET;
        reqTake  = ReqValid && !PRESET;
        if (reqTake) stateNext = CMD;
      end
      CMD: begin
        TxValid = txCan;
        TxData  = CmdByte;
        if (txCan && TxReady) stateNext = ADDR;
      end
      ADDR: begin
        TxValid = txCan;
        case (txCount[1:0])
          2'd1:    TxData = addrQ[23:16];
          2'd2:    TxData = addrQ[15:8];
          default: TxData = addrQ[7:0];
        endcase
        if (txCan && TxReady && (txCount == CntW'(3))) begin
`ifdef SPI_FAST_READ_EN
          stateNext = DUMMY;
`else
          stateNext = DATA;
`endif
        end
      end
      DUMMY: begin
        TxValid = txCan;
        if (txCan && TxReady && (txCount == HeaderLen - CntW'(1))) stateNext = DATA;
      end
      DATA: begin
        TxValid = txCan;
        if (txCan && TxReady && (txCount == lastIdx)) stateNext = WAITRX;
      end
      WAITRX: ;
      DONE:   stateNext = IDLE;
      FLUSH:  if (outCount == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    txFire = TxValid && TxReady;
    rxTake = RxValid && (inTxn || (state == FLUSH));

    // Header echoes are dropped; data echoes go straight out, same cycle
    if (inTxn && RxValid && !Abort && (rxCount >= HeaderLen)) begin
      RspValid = 1'b1;
      RspData  = RxData;
      RspLast  = (rxCount == lastIdx);
      if (RspLast) stateNext = DONE;
    end

    if (Abort && (state != IDLE) && (state != FLUSH)) stateNext = FLUSH;
  end

  // Request capture, byte counters and outstanding-byte tracking
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addrQ    <= '0;
      lenQ     <= '0;
      txCount  <= '0;
      rxCount  <= '0;
      outCount <= '0;
    end else begin
      if (reqTake) begin
        addrQ   <= ReqAddr;
        lenQ    <= ReqLen;
        txCount <= '0;
        rxCount <= '0;
      end else begin
        if (txFire) txCount <= txCount + CntW'(1);
        if (rxTake) rxCount <= rxCount + CntW'(1);
      end
      case ({txFire, rxTake && (outCount != '0)})
        2'b10:   outCount <= outCount + OutW'(1);
        2'b01:   outCount <= outCount - OutW'(1);
        default: outCount <= outCount;
      endcase
    end
  end

endmodule
